part_scan_ctrl: RTL and testbench

// Drives the part-under-test pins on behalf of the part_tester command processor.

---
 rtl/part_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_part_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/part_scan_ctrl.sv
// Part-under-test pin driver: turns decoded scan/execute/free-run commands into
// part_clk pulses, scan-enable/test-mode control and a bit-serial scan stream.
module part_scan_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_count,
    output logic        cmd_ready,
    input  logic        pause,
    input  logic        din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] cycles_run,
    output logic        part_clk,
    output logic        part_se,
    output logic        part_tm,
    output logic        part_scan_in,
    input  logic        part_scan_out
);
    localparam logic [1:0] OP_SET  = 2'd0;
    localparam logic [1:0] OP_GET  = 2'd1;
    localparam logic [1:0] OP_EXEC = 2'd2;
    localparam logic [1:0] OP_FREE = 2'd3;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SCAN_WAIT, CLK_HI, CLK_LO, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cycles_q, cycles_d;
    logic [DW-1:0] div_q, div_d;
    logic cmd_ready_q, cmd_ready_d, din_ready_q, din_ready_d;
    logic dout_q, dout_d, dout_valid_q, dout_valid_d;
    logic busy_q, busy_d, done_q, done_d;
    logic part_clk_q, part_clk_d, part_se_q, part_se_d, part_tm_q, part_tm_d;
    logic scan_in_q, scan_in_d;
    logic start_pulse, scan_op;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        cycles_d    = cycles_q;
        div_d       = div_q;
        scan_in_d   = scan_in_q;
        dout_d      = dout_q;
        start_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d     = cmd_op;
                    cnt_d    = cmd_count;
                    cycles_d = 16'd0;
                    if (cmd_op == OP_FREE) begin
                        start_pulse = 1'b1;
                    end else if (cmd_count == 16'd0) begin
                        state_d = DONE;
                    end else if (cmd_op == OP_EXEC) begin
                        start_pulse = 1'b1;
                    end else begin
                        state_d = SCAN_WAIT;
                        if (cmd_op == OP_GET) dout_d = part_scan_out;
                    end
                end
            end
            SCAN_WAIT: begin
                if (op_q == OP_SET && din_valid && din_ready_q) begin
                    scan_in_d   = din;
                    start_pulse = 1'b1;
                end else if (op_q == OP_GET && dout_valid_q && dout_ready) begin
                    // Recirculate the captured bit so a full-length read leaves the chain intact
                    scan_in_d   = dout_q;
                    start_pulse = 1'b1;
                end
            end
            CLK_HI: begin
                if (div_q == DIV_LAST) begin
                    state_d = CLK_LO;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            CLK_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (op_q == OP_FREE) begin
                        if (pause) state_d = DONE;
                        else       start_pulse = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = DONE;
                        end else if (op_q == OP_EXEC) begin
                            start_pulse = 1'b1;
                        end else begin
                            state_d = SCAN_WAIT;
                            if (op_q == OP_GET) dout_d = part_scan_out;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start_pulse) begin
            state_d = CLK_HI;
            div_d   = '0;
            if (cycles_d != 16'hFFFF) cycles_d = cycles_d + 16'd1;
        end

        // Outputs are registered copies of what the next state implies
        scan_op      = (op_d == OP_SET) || (op_d == OP_GET);
        cmd_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        part_clk_d   = (state_d == CLK_HI);
        din_ready_d  = (state_d == SCAN_WAIT) && (op_d == OP_SET);
        dout_valid_d = (state_d == SCAN_WAIT) && (op_d == OP_GET);
        part_se_d    = scan_op && (state_d != IDLE);
        part_tm_d    = scan_op && (state_d != IDLE);
        if (state_d == IDLE) begin
            scan_in_d = 1'b0;
            dout_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= 2'd0;
            cnt_q        <= 16'd0;
            cycles_q     <= 16'd0;
            div_q        <= '0;
            cmd_ready_q  <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            part_clk_q   <= 1'b0;
            part_se_q    <= 1'b0;
            part_tm_q    <= 1'b0;
            scan_in_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            cycles_q     <= cycles_d;
            div_q        <= div_d;
            cmd_ready_q  <= cmd_ready_d;
            din_ready_q  <= din_ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            part_clk_q   <= part_clk_d;
            part_se_q    <= part_se_d;
            part_tm_q    <= part_tm_d;
            scan_in_q    <= scan_in_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign din_ready    = din_ready_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cycles_run   = cycles_q;
    assign part_clk     = part_clk_q;
    assign part_se      = part_se_q;
    assign part_tm      = part_tm_q;
    assign part_scan_in = scan_in_q;
endmodule

// File: tb/tb_part_scan_ctrl.sv
// Bench for part_scan_ctrl: 5-bit scan chain model on the part pins, pulse
// monitor, and directed/randomized command sequences.
module tb_part_scan_ctrl;
    localparam int CLK_DIV = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 0, pause = 0, din = 0, din_valid = 0, dout_ready = 0;
    logic [1:0] cmd_op = 0;
    logic [15:0] cmd_count = 0;
    logic cmd_ready, din_ready, dout, dout_valid, busy, done;
    logic [15:0] cycles_run;
    logic part_clk, part_se, part_tm, part_scan_in, part_scan_out;

    part_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_count(cmd_count), .cmd_ready(cmd_ready), .pause(pause),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .done(done), .cycles_run(cycles_run),
        .part_clk(part_clk), .part_se(part_se), .part_tm(part_tm),
        .part_scan_in(part_scan_in), .part_scan_out(part_scan_out));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Monitor state: running totals; tests compare deltas across a command
    logic [4:0] chain = 5'b0;
    assign part_scan_out = chain[0];
    int cyc = 0, rises = 0, done_tot = 0, hi_bad = 0, lo_bad = 0;
    int hi_run = 0, lo_run = 0, last_fall = 0, last_done = 0;
    logic prev_pclk = 0, had_fall = 0;
    logic si_hist [0:1023];
    logic se_hist [0:1023];
    logic tm_hist [0:1023];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (part_clk && !prev_pclk) begin
            si_hist[rises % 1024] = part_scan_in;
            se_hist[rises % 1024] = part_se;
            tm_hist[rises % 1024] = part_tm;
            if (!part_se && had_fall && lo_run != CLK_DIV) lo_bad = lo_bad + 1;
            rises  = rises + 1;
            chain  = {part_scan_in, chain[4:1]};
            hi_run = 0;
        end
        if (!part_clk && prev_pclk) begin
            if (hi_run != CLK_DIV) hi_bad = hi_bad + 1;
            last_fall = cyc;
            lo_run    = 0;
            had_fall  = 1;
        end
        if (part_clk) hi_run = hi_run + 1;
        else          lo_run = lo_run + 1;
        if (done) begin
            done_tot  = done_tot + 1;
            last_done = cyc;
        end
        if (cmd_ready || done) had_fall = 0;
        prev_pclk = part_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] cnt);
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin tick(); k++; end
        chk("cmd_ready_before_issue", cmd_ready, 1);
        cmd_op = op; cmd_count = cnt; cmd_valid = 1;
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_done(input int base, input int lim);
        int k;
        k = 0;
        while (done_tot == base && k < lim) begin tick(); k++; end
        chk("done_seen", done_tot - base, 1);
        tick();
        chk("done_single_pulse", done_tot - base, 1);
    endtask

    task automatic run_set(input logic [4:0] bits, input int n, input int gap);
        int r0, d0, r, k, se_ok;
        r0 = rises; d0 = done_tot;
        issue(2'd0, 16'(n));
        for (int i = 0; i < n; i++) begin
            k = 0;
            tick();
            while (!din_ready && k < 100) begin tick(); k++; end
            chk("set_din_ready", din_ready, 1);
            r = rises;
            repeat (gap) tick();
            chk("set_no_pulse_in_gap", rises - r, 0);
            din = bits[i]; din_valid = 1;
            @(posedge clk);
            #1 din_valid = 0;
        end
        wait_done(d0, 100);
        chk("set_pulses", rises - r0, n);
        se_ok = 1;
        for (int i = 0; i < n; i++) begin
            chk("set_scan_in_bit", si_hist[(r0 + i) % 1024], bits[i]);
            if (!se_hist[(r0 + i) % 1024] || !tm_hist[(r0 + i) % 1024]) se_ok = 0;
        end
        chk("set_se_tm_high", se_ok, 1);
        chk("set_cycles_run", cycles_run, n);
    endtask

    task automatic run_get(input logic [4:0] exp_bits, input int n, input int stall);
        int r0, d0, k, stable;
        logic v;
        r0 = rises; d0 = done_tot;
        issue(2'd1, 16'(n));
        for (int i = 0; i < n; i++) begin
            k = 0;
            tick();
            while (!dout_valid && k < 100) begin tick(); k++; end
            chk("get_dout_valid", dout_valid, 1);
            chk("get_dout_bit", dout, exp_bits[i]);
            v = dout; stable = 1;
            repeat (stall) begin
                tick();
                if (dout !== v || dout_valid !== 1'b1) stable = 0;
            end
            chk("get_dout_stable", stable, 1);
            dout_ready = 1;
            @(posedge clk);
            #1 dout_ready = 0;
        end
        wait_done(d0, 100);
        chk("get_pulses", rises - r0, n);
        chk("get_chain_restored", chain, exp_bits);
    endtask

    initial begin
        int r0, d0, n, se_bad, lb0, hb0, k;
        logic [4:0] rb;

        // Reset state
        tick();
        chk("rst_outputs_zero", {cmd_ready, din_ready, dout, dout_valid, busy, done,
            part_clk, part_se, part_tm, part_scan_in}, 0);
        chk("rst_cycles_run", cycles_run, 0);
        rst = 0;
        tick();
        chk("cmd_ready_after_release", cmd_ready, 1);

        // EXECUTE 4, with an ignored command strobe while busy
        r0 = rises; d0 = done_tot; hb0 = hi_bad; lb0 = lo_bad;
        issue(2'd2, 16'd4);
        tick();
        chk("exec_clk_rise_latency", part_clk, 1);
        chk("exec_busy", {busy, cmd_ready}, 2'b10);
        cmd_op = 2'd2; cmd_count = 16'd7; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        wait_done(d0, 100);
        chk("exec_pulses", rises - r0, 4);
        chk("exec_cycles_run", cycles_run, 4);
        chk("exec_hi_width", hi_bad - hb0, 0);
        chk("exec_lo_width", lo_bad - lb0, 0);
        chk("exec_done_after_lo", last_done - last_fall, CLK_DIV);
        se_bad = 0;
        for (int i = 0; i < 4; i++)
            if (se_hist[(r0 + i) % 1024] || tm_hist[(r0 + i) % 1024]) se_bad++;
        chk("exec_se_tm_low", se_bad, 0);
        chk("idle_pins_low", {part_clk, part_se, part_tm, part_scan_in, din_ready, dout_valid}, 0);

        // EXECUTE 0
        r0 = rises; d0 = done_tot;
        issue(2'd2, 16'd0);
        tick();
        chk("exec0_done_next", done, 1);
        tick();
        chk("exec0_no_pulse", rises - r0, 0);
        chk("exec0_cycles_run", cycles_run, 0);

        // EXECUTE random count with pause held: pause must be ignored
        n = $urandom_range(3, 9);
        r0 = rises; d0 = done_tot; lb0 = lo_bad;
        pause = 1;
        issue(2'd2, 16'(n));
        wait_done(d0, 200);
        pause = 0;
        chk("exec_rand_pulses", rises - r0, n);
        chk("exec_rand_cycles_run", cycles_run, n);
        chk("exec_rand_lo_width", lo_bad - lb0, 0);

        // SET_STATE directed 1,0,1,1 (LSB first), 3-cycle gaps
        run_set(5'b01101, 4, 3);

        // GET_STATE on chain preloaded 10110, 3-cycle stalls
        chain = 5'b10110;
        run_get(5'b10110, 5, 3);

        // Random load through SET then read back through GET
        rb = 5'($urandom);
        run_set(rb, 5, $urandom_range(0, 4));
        chk("set_chain_loaded", chain, rb);
        run_get(rb, 5, $urandom_range(0, 4));

        // FREE_RUN, pause raised during pulse n
        n = $urandom_range(2, 8);
        if (n == 2) n = 6;
        r0 = rises; d0 = done_tot;
        issue(2'd3, 16'd0);
        k = 0;
        while (rises - r0 < n && k < 300) begin tick(); k++; end
        chk("free_reached_pulse", rises - r0, n);
        pause = 1;
        wait_done(d0, 100);
        pause = 0;
        chk("free_pulses", rises - r0, n);
        chk("free_cycles_run", cycles_run, n);
        chk("free_pulse_completed", last_done - last_fall, CLK_DIV);

        // Reset in the middle of a GET_STATE pulse
        chain = 5'b10110;
        issue(2'd1, 16'd5);
        k = 0;
        tick();
        while (!dout_valid && k < 100) begin tick(); k++; end
        dout_ready = 1;
        @(posedge clk);
        #1 dout_ready = 0;
        k = 0;
        tick();
        while (!part_clk && k < 100) begin tick(); k++; end
        chk("get_mid_pulse_reached", {part_clk, part_se}, 2'b11);
        #1 rst = 1;
        #1;
        chk("rst_abort_pins", {part_clk, part_se, part_tm, dout_valid, busy}, 0);
        tick();
        tick();
        rst = 0;
        @(posedge clk);
        #1;
        chk("rst_abort_cmd_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
